// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file.
// NRD registered read ports with write-to-read bypass, two prioritised write
// ports (port 1 wins on address collision) and a per-entry busy scoreboard.
// Every read port returns the value and busy state the addressed entry holds
// after the current edge, so rdata and rbusy always describe the same moment.
module regfile_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NRD     = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NRD*ADDR_W-1:0]   raddr,
    output logic [NRD*DATA_W-1:0]   rdata,
    output logic [NRD-1:0]          rbusy,
    input  logic                    we0,
    input  logic [ADDR_W-1:0]       waddr0,
    input  logic [DATA_W-1:0]       wdata0,
    input  logic                    we1,
    input  logic [ADDR_W-1:0]       waddr1,
    input  logic [DATA_W-1:0]       wdata1,
    input  logic                    bset,
    input  logic [ADDR_W-1:0]       bset_addr
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam bit R0_HARD = (ZERO_R0 != 0);

    // Architectural state and its next-state values
    logic [DATA_W-1:0]     rf_q    [DEPTH];
    logic [DATA_W-1:0]     rf_d    [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;
    logic [NRD*DATA_W-1:0] rdata_q;
    logic [NRD*DATA_W-1:0] rdata_d;
    logic [NRD-1:0]        rbusy_q;
    logic [NRD-1:0]        rbusy_d;

    // Per-port read addresses unpacked from the flat bus
    logic [ADDR_W-1:0]     ra      [NRD];

    // Effective write strobes: a hard-wired zero entry swallows writes
    logic                  wr0_en;
    logic                  wr1_en;

    assign wr0_en = we0 && !(R0_HARD && (waddr0 == '0));
    assign wr1_en = we1 && !(R0_HARD && (waddr1 == '0));

    assign rdata = rdata_q;
    assign rbusy = rbusy_q;

    // Split the flat read-address bus into one address per port
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            ra[i] = raddr[i*ADDR_W +: ADDR_W];
        end
    end

    // Next-state storage: port 0 first, port 1 second so the younger result wins
    always_comb begin
        // NOTE: every combinational output is given a full default before any
        // conditional update, so no path leaves it unassigned and no latch forms.
        for (int k = 0; k < DEPTH; k++) begin
            rf_d[k] = rf_q[k];
        end
        if (wr0_en) begin
            rf_d[waddr0] = wdata0;
        end
        if (wr1_en) begin
            rf_d[waddr1] = wdata1;
        end
    end

    // Next-state scoreboard: retiring writes clear, a new producer sets (set wins)
    always_comb begin
        busy_d = busy_q;
        if (we0) begin
            busy_d[waddr0] = 1'b0;
        end
        if (we1) begin
            busy_d[waddr1] = 1'b0;
        end
        if (bset) begin
            busy_d[bset_addr] = 1'b1;
        end
        if (R0_HARD) begin
            busy_d[0] = 1'b0;
        end
    end

    // Read selection: zero entry, then port 1 bypass, then port 0 bypass, then storage
    always_comb begin
        rdata_d = '0;
        rbusy_d = '0;
        for (int i = 0; i < NRD; i++) begin
            if (R0_HARD && (ra[i] == '0)) begin
                rdata_d[i*DATA_W +: DATA_W] = '0;
            end else if (we1 && (waddr1 == ra[i])) begin
                rdata_d[i*DATA_W +: DATA_W] = wdata1;
            end else if (we0 && (waddr0 == ra[i])) begin
                rdata_d[i*DATA_W +: DATA_W] = wdata0;
            end else begin
                rdata_d[i*DATA_W +: DATA_W] = rf_q[ra[i]];
            end
            rbusy_d[i] = busy_d[ra[i]];
        end
    end

    // State registers with synchronous reset that overrides writes and sets
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the values from before this edge, independent of statement order.
        if (reset) begin
            // NOTE: the storage array is reset along with the control state
            // because the register file must read as zero straight after reset.
            for (int k = 0; k < DEPTH; k++) begin
                rf_q[k] <= '0;
            end
            busy_q  <= '0;
            rdata_q <= '0;
            rbusy_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                rf_q[k] <= rf_d[k];
            end
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
            rbusy_q <= rbusy_d;
        end
    end

endmodule
